// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, load-use stall, branch
// redirect flush, and a RUN/MEM_WAIT FSM that freezes the pipe while the data
// memory is busy, with a bounded wait and a sticky timeout flag.
// Optional performance counters are built only when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl #(
    parameter int ADDR_WIDTH  = 5,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [ADDR_WIDTH-1:0] i_rs1_addr_d,
    input  logic [ADDR_WIDTH-1:0] i_rs2_addr_d,
    input  logic [ADDR_WIDTH-1:0] i_rs1_addr_e,
    input  logic [ADDR_WIDTH-1:0] i_rs2_addr_e,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr_e,
    input  logic [1:0]            i_resultsrc_e,
    input  logic                  i_pcsrc_e,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr_m,
    input  logic                  i_regwrite_m,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr_w,
    input  logic                  i_regwrite_w,
    input  logic                  i_dmem_req_m,
    input  logic                  i_dmem_ack_m,
    output logic                  o_stall_f,
    output logic                  o_stall_d,
    output logic                  o_stall_e,
    output logic                  o_stall_m,
    output logic                  o_flush_d,
    output logic                  o_flush_e,
    output logic [1:0]            o_fwd_a_e,
    output logic [1:0]            o_fwd_b_e,
    output logic                  o_mem_wait,
    output logic                  o_mem_err,
    output logic [CNT_WIDTH-1:0]  o_stall_cnt,
    output logic [CNT_WIDTH-1:0]  o_flush_cnt
);

    localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [WAIT_W-1:0]   wait_cnt_q;
    logic                mem_stall;
    logic                timeout;
    logic                load_use;

    // Forwarding select: memory stage wins over writeback, register 0 never forwards
    always_comb begin
        o_fwd_a_e = 2'b00;
        o_fwd_b_e = 2'b00;
        if (i_regwrite_m && (i_rd_addr_m != '0) && (i_rd_addr_m == i_rs1_addr_e))
            o_fwd_a_e = 2'b10;
        else if (i_regwrite_w && (i_rd_addr_w != '0) && (i_rd_addr_w == i_rs1_addr_e))
            o_fwd_a_e = 2'b01;
        if (i_regwrite_m && (i_rd_addr_m != '0) && (i_rd_addr_m == i_rs2_addr_e))
            o_fwd_b_e = 2'b10;
        else if (i_regwrite_w && (i_rd_addr_w != '0) && (i_rd_addr_w == i_rs2_addr_e))
            o_fwd_b_e = 2'b01;
    end

    // Load in execute whose destination is read by the instruction in decode
    always_comb begin
        load_use = (i_resultsrc_e == 2'b01) && (i_rd_addr_e != '0) &&
                   ((i_rd_addr_e == i_rs1_addr_d) || (i_rd_addr_e == i_rs2_addr_d));
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst)
            state_q <= RUN;
        else
            state_q <= state_d;
    end

    // Next state, memory stall decode and stall/flush outputs
    always_comb begin
        state_d   = state_q;
        mem_stall = 1'b0;
        timeout   = 1'b0;
        o_stall_f = 1'b0;
        o_stall_d = 1'b0;
        o_stall_e = 1'b0;
        o_stall_m = 1'b0;
        o_flush_d = 1'b0;
        o_flush_e = 1'b0;
        case (state_q)
            RUN: begin
                if (i_dmem_req_m && !i_dmem_ack_m) begin
                    state_d   = MEM_WAIT;
                    mem_stall = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (i_dmem_ack_m) begin
                    state_d = RUN;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d = RUN;
                    timeout = 1'b1;
                end else begin
                    mem_stall = 1'b1;
                end
            end
            default: state_d = RUN;
        endcase

        // Memory stall freezes everything and masks pipeline hazards; once the
        // freeze lifts, hazards held in the frozen stages are resolved normally
        if (mem_stall) begin
            o_stall_f = 1'b1;
            o_stall_d = 1'b1;
            o_stall_e = 1'b1;
            o_stall_m = 1'b1;
        end else if (i_pcsrc_e) begin
            o_flush_d = 1'b1;
            o_flush_e = 1'b1;
        end else if (load_use) begin
            o_stall_f = 1'b1;
            o_stall_d = 1'b1;
            o_flush_e = 1'b1;
        end
    end

    // Wait counter: held at zero in RUN so it starts from zero on entry
    always_ff @(posedge i_clk) begin
        if (i_rst || (state_q == RUN))
            wait_cnt_q <= '0;
        else
            wait_cnt_q <= wait_cnt_q + 1'b1;
    end

    // Sticky timeout flag, cleared only by reset
    always_ff @(posedge i_clk) begin
        if (i_rst)
            o_mem_err <= 1'b0;
        else if (timeout)
            o_mem_err <= 1'b1;
    end

    always_comb begin
        o_mem_wait = (state_q == MEM_WAIT);
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] stall_cnt_q;
    logic [CNT_WIDTH-1:0] flush_cnt_q;

    // Performance counters, wrapping naturally at all-ones
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (o_stall_d)
                stall_cnt_q <= stall_cnt_q + 1'b1;
            if (o_flush_e)
                flush_cnt_q <= flush_cnt_q + 1'b1;
        end
    end

    assign o_stall_cnt = stall_cnt_q;
    assign o_flush_cnt = flush_cnt_q;
`else
    assign o_stall_cnt = '0;
    assign o_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl.
module tb_hazard_ctrl;

    localparam int AW = 5;
    localparam int CW = 32;

`ifdef HAZARD_PERF_CNT_EN
    localparam int EXP_STALL_CNT = 3;
    localparam int EXP_FLUSH_CNT = 5;
`else
    localparam int EXP_STALL_CNT = 0;
    localparam int EXP_FLUSH_CNT = 0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic [1:0]    resultsrc_e;
    logic          pcsrc_e, regwrite_m, regwrite_w, dmem_req, dmem_ack;
    logic          stall_f, stall_d, stall_e, stall_m, flush_d, flush_e;
    logic [1:0]    fwd_a, fwd_b;
    logic          mem_wait, mem_err;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int total = 0;
    int bad   = 0;
    int n;

    hazard_ctrl #(.ADDR_WIDTH(AW), .MEM_TIMEOUT(16), .CNT_WIDTH(CW)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_rs1_addr_d(rs1_d), .i_rs2_addr_d(rs2_d),
        .i_rs1_addr_e(rs1_e), .i_rs2_addr_e(rs2_e), .i_rd_addr_e(rd_e),
        .i_resultsrc_e(resultsrc_e), .i_pcsrc_e(pcsrc_e),
        .i_rd_addr_m(rd_m), .i_regwrite_m(regwrite_m),
        .i_rd_addr_w(rd_w), .i_regwrite_w(regwrite_w),
        .i_dmem_req_m(dmem_req), .i_dmem_ack_m(dmem_ack),
        .o_stall_f(stall_f), .o_stall_d(stall_d), .o_stall_e(stall_e), .o_stall_m(stall_m),
        .o_flush_d(flush_d), .o_flush_e(flush_e),
        .o_fwd_a_e(fwd_a), .o_fwd_b_e(fwd_b),
        .o_mem_wait(mem_wait), .o_mem_err(mem_err),
        .o_stall_cnt(stall_cnt), .o_flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_inputs();
        rs1_d = '0; rs2_d = '0; rs1_e = '0; rs2_e = '0; rd_e = '0;
        rd_m = '0; rd_w = '0; resultsrc_e = 2'b00; pcsrc_e = 1'b0;
        regwrite_m = 1'b0; regwrite_w = 1'b0; dmem_req = 1'b0; dmem_ack = 1'b0;
    endtask

    initial begin
        clr_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rst_mem_wait", mem_wait, 0);
        check("rst_mem_err", mem_err, 0);
        check("rst_stall_f", stall_f, 0);
        check("rst_flush_e", flush_e, 0);
        check("rst_fwd_a", fwd_a, 0);
        check("rst_stall_cnt", stall_cnt, 0);
        check("rst_flush_cnt", flush_cnt, 0);

        // Load-use on rs2: one bubble cycle (load-use #1)
        tick();
        rd_e = 5'd5; resultsrc_e = 2'b01; rs2_d = 5'd5;
        #1;
        check("lu_stall_f", stall_f, 1);
        check("lu_stall_d", stall_d, 1);
        check("lu_flush_e", flush_e, 1);
        check("lu_flush_d", flush_d, 0);
        check("lu_stall_e", stall_e, 0);
        // Bubble now in execute
        tick();
        resultsrc_e = 2'b00; rd_e = '0;
        #1;
        check("lu_release", stall_d, 0);
        // Destination x0 never stalls
        tick();
        rd_e = '0; rs2_d = '0; resultsrc_e = 2'b01;
        #1;
        check("lu_x0", stall_d, 0);
        // Non-load match never stalls
        tick();
        rd_e = 5'd9; rs1_d = 5'd9; resultsrc_e = 2'b00;
        #1;
        check("lu_nonload", stall_d, 0);
        // Load-use on rs1 (load-use #2)
        tick();
        rd_e = 5'd7; rs1_d = 5'd7; resultsrc_e = 2'b01;
        #1;
        check("lu_rs1_stall_f", stall_f, 1);
        tick();
        clr_inputs();

        // Forwarding
        regwrite_m = 1'b1; rd_m = 5'd3; regwrite_w = 1'b1; rd_w = 5'd3;
        rs1_e = 5'd3; rs2_e = 5'd4;
        #1;
        check("fwd_a_mem", fwd_a, 2'b10);
        check("fwd_b_none", fwd_b, 2'b00);
        regwrite_m = 1'b0;
        #1;
        check("fwd_a_wb", fwd_a, 2'b01);
        rd_w = 5'd4; rs2_e = 5'd4;
        #1;
        check("fwd_b_wb", fwd_b, 2'b01);
        regwrite_m = 1'b1; rd_m = '0; rd_w = '0; rs1_e = '0; rs2_e = '0;
        #1;
        check("fwd_a_x0", fwd_a, 2'b00);
        check("fwd_b_x0", fwd_b, 2'b00);
        tick();
        clr_inputs();

        // Redirect with simultaneous load-use: redirect wins (redirect #1)
        rd_e = 5'd5; resultsrc_e = 2'b01; rs2_d = 5'd5; pcsrc_e = 1'b1;
        #1;
        check("br_flush_d", flush_d, 1);
        check("br_flush_e", flush_e, 1);
        check("br_stall_f", stall_f, 0);
        check("br_stall_d", stall_d, 0);
        // Load-use alone (load-use #3)
        tick();
        pcsrc_e = 1'b0;
        #1;
        check("lu3_stall_d", stall_d, 1);
        // Redirect alone (redirect #2)
        tick();
        clr_inputs();
        pcsrc_e = 1'b1;
        #1;
        check("br2_flush_d", flush_d, 1);
        tick();
        clr_inputs();
        #1;
        check("perf_stall_cnt", stall_cnt, EXP_STALL_CNT);
        check("perf_flush_cnt", flush_cnt, EXP_FLUSH_CNT);

        // Memory wait, ack four cycles after request; redirect is masked
        dmem_req = 1'b1; pcsrc_e = 1'b1;
        #1;
        check("mw_req_stall_m", stall_m, 1);
        check("mw_req_stall_f", stall_f, 1);
        check("mw_req_flush_d", flush_d, 0);
        check("mw_req_state", mem_wait, 0);
        for (int i = 1; i < 4; i++) begin
            tick();
            pcsrc_e = 1'b0;
            #1;
            check($sformatf("mw_wait%0d_stall_e", i), stall_e, 1);
            check($sformatf("mw_wait%0d_state", i), mem_wait, 1);
        end
        tick();
        dmem_ack = 1'b1;
        #1;
        check("mw_ack_stall_m", stall_m, 0);
        check("mw_ack_stall_f", stall_f, 0);
        check("mw_ack_state", mem_wait, 1);
        tick();
        clr_inputs();
        #1;
        check("mw_done_state", mem_wait, 0);
        check("mw_done_err", mem_err, 0);

        // Ack together with request: no stall, no state change
        dmem_req = 1'b1; dmem_ack = 1'b1;
        #1;
        check("same_ack_stall", stall_m, 0);
        tick();
        clr_inputs();
        #1;
        check("same_ack_state", mem_wait, 0);

        // Timeout: ack never arrives
        dmem_req = 1'b1;
        #1;
        n = 0;
        while (stall_m && n < 40) begin
            n++;
            tick();
        end
        check("to_stall_cycles", n, 16);
        check("to_release", stall_m, 0);
        check("to_last_state", mem_wait, 1);
        check("to_err_not_yet", mem_err, 0);
        tick();
        dmem_req = 1'b0;
        #1;
        check("to_err_set", mem_err, 1);
        check("to_back_run", mem_wait, 0);
        tick();
        tick();
        check("to_err_sticky", mem_err, 1);

        // Reset in the middle of a wait aborts it and clears the error
        dmem_req = 1'b1;
        tick();
        tick();
        check("rw_in_wait", mem_wait, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0; dmem_req = 1'b0;
        #1;
        check("rw_state", mem_wait, 0);
        check("rw_err", mem_err, 0);
        check("rw_stall", stall_m, 0);
        check("rw_stall_cnt", stall_cnt, 0);
        check("rw_flush_cnt", flush_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
